// File: rtl/du_stage_reg_way1.sv
// Way-1 decode->execute stage register: two-entry skid buffer with registered
// ready, full flush and per-packet-ID selective squash.
module du_stage_reg_way1 #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            rdAddr_i,
  input  logic                  rdWriteEnable_i,
  input  logic [XLEN-1:0]       rs1ReadData_i,
  input  logic [XLEN-1:0]       rs2ReadData_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [6:0]            opCode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [5:0]            shamt_i,
  input  logic [PID_W-1:0]      pID_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [4:0]            rdAddr_o,
  output logic                  rdWriteEnable_o,
  output logic [XLEN-1:0]       rs1ReadData_o,
  output logic [XLEN-1:0]       rs2ReadData_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [6:0]            opCode_o,
  output logic [2:0]            funct3_o,
  output logic [6:0]            funct7_o,
  output logic [5:0]            shamt_o,
  output logic [PID_W-1:0]      pID_o,
  input  logic                  flush_i,
  input  logic [(1<<PID_W)-1:0] squashMask_i,
  output logic [1:0]            occupancy_o
);

  typedef struct packed {
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [5:0]       shamt;
    logic [PID_W-1:0] pid;
  } bundle_t;

  bundle_t main_q, skid_q, main_d, skid_d, in_b;
  logic    main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic    in_live, main_live, skid_live, pop;

  assign in_b = '{rd_addr: rdAddr_i, rd_we: rdWriteEnable_i, rs1: rs1ReadData_i,
                  rs2: rs2ReadData_i, imm: imm_i, opcode: opCode_i, funct3: funct3_i,
                  funct7: funct7_i, shamt: shamt_i, pid: pID_i};

  // Squash is applied first; push/pop only ever sees the surviving entries.
  assign in_live   = valid_i && ready_o && !squashMask_i[pID_i];
  assign main_live = main_valid && !squashMask_i[main_q.pid];
  assign skid_live = skid_valid && !squashMask_i[skid_q.pid];
  assign pop       = main_live && ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_live;
    skid_valid_d = skid_live;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_live || pop) begin
      // Head slot frees up: skid advances first so ordering stays FIFO.
      if (skid_live) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_live;
        if (in_live) skid_d = in_b;
      end else begin
        main_valid_d = in_live;
        skid_valid_d = 1'b0;
        if (in_live) main_d = in_b;
      end
    end else if (!skid_live) begin
      skid_valid_d = in_live;
      if (in_live) skid_d = in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  assign ready_o         = !skid_valid;
  assign valid_o         = main_valid;
  assign occupancy_o     = {1'b0, main_valid} + {1'b0, skid_valid};
  assign rdAddr_o        = main_q.rd_addr;
  assign rdWriteEnable_o = main_q.rd_we;
  assign rs1ReadData_o   = main_q.rs1;
  assign rs2ReadData_o   = main_q.rs2;
  assign imm_o           = main_q.imm;
  assign opCode_o        = main_q.opcode;
  assign funct3_o        = main_q.funct3;
  assign funct7_o        = main_q.funct7;
  assign shamt_o         = main_q.shamt;
  assign pID_o           = main_q.pid;

endmodule

// File: tb/tb_du_stage_reg_way1.sv
// Bench for du_stage_reg_way1: directed scenarios plus random traffic, all
// checked against a queue-based model of the stage.
module tb_du_stage_reg_way1;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned PID_W = 2;
  localparam int unsigned NP    = 1 << PID_W;

  typedef struct packed {
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [5:0]       shamt;
    logic [PID_W-1:0] pid;
  } bun_t;

  logic clk = 1'b0;
  logic rst;
  logic valid_i, ready_o, ready_i, valid_o, flush_i;
  logic [NP-1:0] squashMask_i;
  logic [1:0] occupancy_o;
  bun_t din, dout;

  logic [4:0]       rdAddr_o;
  logic             rdWriteEnable_o;
  logic [XLEN-1:0]  rs1ReadData_o, rs2ReadData_o, imm_o;
  logic [6:0]       opCode_o, funct7_o;
  logic [2:0]       funct3_o;
  logic [5:0]       shamt_o;
  logic [PID_W-1:0] pID_o;

  always #5 clk = ~clk;

  du_stage_reg_way1 #(.XLEN(XLEN), .PID_W(PID_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .rdAddr_i(din.rd_addr), .rdWriteEnable_i(din.rd_we),
    .rs1ReadData_i(din.rs1), .rs2ReadData_i(din.rs2), .imm_i(din.imm),
    .opCode_i(din.opcode), .funct3_i(din.funct3), .funct7_i(din.funct7),
    .shamt_i(din.shamt), .pID_i(din.pid), .ready_i(ready_i), .valid_o(valid_o),
    .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o),
    .rs1ReadData_o(rs1ReadData_o), .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o),
    .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .shamt_o(shamt_o), .pID_o(pID_o), .flush_i(flush_i),
    .squashMask_i(squashMask_i), .occupancy_o(occupancy_o)
  );

  assign dout = '{rd_addr: rdAddr_o, rd_we: rdWriteEnable_o, rs1: rs1ReadData_o,
                  rs2: rs2ReadData_o, imm: imm_o, opcode: opCode_o, funct3: funct3_o,
                  funct7: funct7_o, shamt: shamt_o, pid: pID_o};

  int checks = 0;
  int failures = 0;
  bun_t q[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bun_t rand_bun(input int unsigned pid);
    logic [255:0] r;
    bun_t b;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = r[$bits(bun_t)-1:0];
    b.pid = pid[PID_W-1:0];
    return b;
  endfunction

  // Stage as an ordered list of at most two bundles.
  task automatic model_step();
    bun_t nq[$];
    bit acc, popd;
    acc  = valid_i && (q.size() < 2) && !squashMask_i[din.pid];
    popd = ready_i && (q.size() > 0) && !squashMask_i[q[0].pid];
    if (flush_i) begin
      q.delete();
    end else begin
      if (popd) void'(q.pop_front());
      foreach (q[i]) if (!squashMask_i[q[i].pid]) nq.push_back(q[i]);
      q = nq;
      if (acc) q.push_back(din);
    end
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, ":valid"}, 256'(valid_o), 256'(q.size() > 0));
    check_eq({tag, ":ready"}, 256'(ready_o), 256'(q.size() < 2));
    check_eq({tag, ":occ"}, 256'(occupancy_o), 256'(q.size()));
    if (q.size() > 0) check_eq({tag, ":head"}, 256'(dout), 256'(q[0]));
  endtask

  task automatic cyc(input logic v, input logic rdy, input logic fl,
                     input logic [NP-1:0] m, input bun_t b, input string tag);
    valid_i = v; ready_i = rdy; flush_i = fl; squashMask_i = m; din = b;
    @(posedge clk);
    model_step();
    #1 check_outs(tag);
  endtask

  initial begin
    bun_t a, b, c;
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    squashMask_i = '0; din = '0;
    #12;
    check_eq("rst:valid", 256'(valid_o), 256'(0));
    check_eq("rst:ready", 256'(ready_o), 256'(1));
    check_eq("rst:occ", 256'(occupancy_o), 256'(0));
    check_eq("rst:data", 256'(dout), 256'(0));
    rst = 1'b1;

    // single transfer
    a = rand_bun(1);
    a.imm = 64'hFFFF_FFFF_FFFF_F800;
    a.rd_addr = 5'd5;
    cyc(1, 1, 0, '0, a, "single0");
    check_eq("single:imm", 256'(imm_o), 256'(64'hFFFF_FFFF_FFFF_F800));
    cyc(0, 1, 0, '0, rand_bun(0), "single1");
    cyc(0, 1, 0, '0, rand_bun(0), "single2");

    // backpressure fill, C held upstream until taken
    a = rand_bun(0); b = rand_bun(1); c = rand_bun(2);
    cyc(1, 0, 0, '0, a, "bp_a");
    cyc(1, 0, 0, '0, b, "bp_b");
    cyc(1, 0, 0, '0, c, "bp_hold");
    cyc(1, 1, 0, '0, c, "bp_popa");
    cyc(1, 1, 0, '0, c, "bp_popb");
    check_eq("bp:head_is_c", 256'(dout), 256'(c));
    cyc(0, 1, 0, '0, rand_bun(0), "bp_popc");
    cyc(0, 1, 0, '0, rand_bun(0), "bp_empty");

    // streaming
    for (int unsigned i = 0; i < 20; i++) cyc(1, 1, 0, '0, rand_bun(i % NP), "stream");
    cyc(0, 1, 0, '0, rand_bun(0), "stream_end");

    // flush with full stage and a bundle at the input
    cyc(1, 0, 0, '0, rand_bun(0), "fl_a");
    cyc(1, 0, 0, '0, rand_bun(1), "fl_b");
    cyc(1, 0, 1, '0, rand_bun(2), "flush");
    check_eq("flush:occ", 256'(occupancy_o), 256'(0));
    cyc(0, 1, 0, '0, rand_bun(0), "fl_after");

    // selective squash
    cyc(1, 0, 0, '0, rand_bun(2), "sq_main");
    cyc(1, 0, 0, '0, rand_bun(3), "sq_skid");
    cyc(0, 0, 0, 4'b0100, rand_bun(0), "sq_p2");
    check_eq("sq:head_pid", 256'(pID_o), 256'(3));
    cyc(0, 1, 0, 4'b1000, rand_bun(0), "sq_p3");
    check_eq("sq:valid_gone", 256'(valid_o), 256'(0));

    // async reset mid-cycle with the stage full
    cyc(1, 0, 0, '0, rand_bun(0), "ar_a");
    cyc(1, 0, 0, '0, rand_bun(1), "ar_b");
    valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    check_eq("arst:valid", 256'(valid_o), 256'(0));
    check_eq("arst:ready", 256'(ready_o), 256'(1));
    check_eq("arst:occ", 256'(occupancy_o), 256'(0));
    check_eq("arst:data", 256'(dout), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 1, 0, '0, rand_bun(2), "ar_xfer");
    cyc(0, 1, 0, '0, rand_bun(0), "ar_done");

    // random traffic
    for (int unsigned i = 0; i < 500; i++) begin
      logic [NP-1:0] m;
      m = ($urandom % 8 == 0) ? NP'($urandom) : '0;
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 30) == 0, m,
          rand_bun($urandom % NP), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/du_stage_reg_way1.md
Name: du_stage_reg_way1

Overview:
- Receiving end of the way-1 decode→execute valid/ready interface: captures each decoded bundle from the way-1 decoder and presents it, registered, to the execute unit.
- Two-entry skid buffer, so ready_o is a registered signal and never combinationally depends on ready_i.
- Supports a full flush and a per-pID selective squash, for mispredict/trap recovery on the dual-issue core.

Parameters:
XLEN, 64, data and immediate width
PID_W, 2, packet-ID width; the squash mask is 2^PID_W bits wide

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-low
valid_i  input  1  decoder bundle valid
ready_o  output  1  stage can accept a bundle; registered
rdAddr_i  input  5  destination register
rdWriteEnable_i  input  1  rd write enable
rs1ReadData_i  input  XLEN  rs1 operand
rs2ReadData_i  input  XLEN  rs2 operand
imm_i  input  XLEN  sign-extended immediate
opCode_i  input  7  opcode
funct3_i  input  3  funct3
funct7_i  input  7  funct7
shamt_i  input  6  shift amount
pID_i  input  PID_W  packet ID
ready_i  input  1  execute unit accepts the head bundle
valid_o  output  1  head bundle valid
rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o  output  same widths as inputs  head bundle fields
flush_i  input  1  discard all held and incoming bundles
squashMask_i  input  2^PID_W  bit k set: discard every bundle with pID==k
occupancy_o  output  2  number of valid entries (0..2)

Behaviour:
- Reset (rst low, async):
  - main and skid entries invalid; valid_o=0, ready_o=1, occupancy_o=0.
  - All data outputs are 0.
- Storage:
  - Main entry drives all *_o ports directly; skid entry is internal.
  - An input is taken when valid_i&&ready_o at the rising edge.
  - Input-to-output latency is 1 cycle; there is no combinational pass-through.
- Handshake:
  - Head pops when valid_o&&ready_i.
  - ready_o = !skid_valid, registered.
  - valid_o and the *_o fields stay stable while valid_o&&!ready_i.
  - A transfer attempted while ready_o=0 is ignored by the stage; the upstream must hold it.
- Next-state rules, evaluated in this order at each edge:
  1. flush_i=1: both entries invalid, the input is dropped, and ready_o=1 next cycle. flush_i dominates squashMask_i and every handshake.
  2. Squash: any entry (main, skid, or the incoming bundle) whose squashMask_i[pID] bit is set is treated as invalid before the push/pop rules apply.
  3. Push/pop, applied to the surviving entries:
     - Main empty: the incoming bundle goes to main. If skid survives and main does not, skid moves to main, and the incoming bundle then goes to skid.
     - Main valid and popped: skid (if valid) moves to main and the incoming bundle goes to skid; otherwise the incoming bundle goes to main.
     - Main valid and not popped: the incoming bundle goes to skid. This is only possible when ready_o=1.
  - Order is strictly FIFO; a skid bundle never overtakes main.
- occupancy_o equals main_valid + skid_valid, registered; it is never 3.
- A squashed head bundle is dropped even if ready_i was high that cycle. The EU must itself ignore a handshake that coincides with a squash of the same pID.
- Invalid entries hold their stale data; only valid_o qualifies the *_o fields.
- Reset asserted mid-transfer: both entries clear immediately and asynchronously; there is no partial state.

Test Plan:
- Single transfer: reset release, send one bundle (imm=0xFFFF_FFFF_FFFF_F800, rdAddr=5, pID=1) with ready_i=1. valid_o rises 1 cycle later with identical fields and falls the following cycle; occupancy_o goes 0→1→0.
- Backpressure fill: ready_i=0, send A then B. After B, ready_o=0 and occupancy_o=2; a third bundle C held on valid_i is not taken. Raise ready_i: outputs A, then B, then C, with no loss or duplication.
- Streaming: valid_i=1 and ready_i=1 every cycle for 20 bundles with pID cycling 0..3. Exactly one bundle is output per cycle in order; ready_o stays 1 and occupancy_o stays 1.
- Flush: with occupancy 2 and a new bundle at the input, assert flush_i for 1 cycle. The next cycle has valid_o=0, occupancy_o=0, ready_o=1, and the incoming bundle never appears.
- Selective squash: main pID=2, skid pID=3, squashMask_i=4'b0100. Next cycle the pID=3 bundle is at the head, occupancy_o=1, ready_o=1. Then squashMask_i=4'b1000 together with ready_i=1 leaves valid_o=0.
- Async reset: assert rst low mid-cycle while occupancy=2. valid_o=0 and ready_o=1 immediately, without waiting for a clock edge; after release, a normal transfer completes.
